branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Parametrised fetch-stage branch predictor for the 5-stage pipelined RV32I core. It replaces the fixed "predict not-taken, resolve in EX" PC selection.
- A direct-mapped BTB with 2-bit saturating counters supplies the predicted next PC in IF.
- EX-stage resolution updates the table, detects mispredicts, and drives the flush/redirect that feeds the hazard logic.
- Saturating performance counters are included.

Parameters:
WIDTH, 32, address/data width
ENTRIES, 16, BTB/BHT entries; power of two, 2..256
TAG_BITS, 8, stored tag width taken from PC above the index bits
CNT_WIDTH, 16, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
PC_F  in  WIDTH  fetch PC for lookup
predict_taken_F  out  1  predicted taken for PC_F
predict_target_F  out  WIDTH  predicted target (valid when predict_taken_F=1)
update_valid_E  in  1  EX holds a resolved branch/jump this cycle
is_jump_E  in  1  resolved instruction is JAL/JALR (always taken)
PC_E  in  WIDTH  PC of the resolved instruction
PCP4_E  in  WIDTH  PC_E+4
taken_E  in  1  actual outcome
target_E  in  WIDTH  actual target (branch PC+imm or JALR ALU result)
pred_taken_E  in  1  prediction made in IF, carried down the pipeline registers
pred_target_E  in  WIDTH  predicted target, carried down the pipeline registers
mispredict  out  1  flush IF/ID and ID/EX; redirect fetch
redirect_pc  out  WIDTH  correct next PC when mispredict=1
stats_clr  in  1  synchronous clear of performance counters
branch_count  out  CNT_WIDTH  resolved updates seen
mispredict_count  out  CNT_WIDTH  mispredicts seen

Behaviour:
- IDX_BITS = log2(ENTRIES).
- index = PC[IDX_BITS+1:2].
- tag = PC[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- Entry contents: valid, tag, target[WIDTH], ctr[1:0], jump flag.
- Reset (async):
  - All valid bits = 0.
  - Counters = 0.
  - Outputs: predict_taken_F=0, mispredict=0, branch_count=0, mispredict_count=0.
  - Ctr/target/tag storage need not be reset.
- Lookup (combinational, zero latency):
  - hit = valid & tag match.
  - predict_taken_F = hit & (jump | ctr[1]).
  - predict_target_F = entry target.
  - On a miss, predict_target_F = 0.
- Update (on clk edge when update_valid_E=1):
  - Hit, branch: ctr increments if taken_E, decrements if not, saturating at 0 and 3. Target is written when taken_E=1.
  - Hit, jump: ctr = 3, target = target_E.
  - Miss, taken_E=1: allocate (overwrite). valid=1, tag, target=target_E, jump=is_jump_E, ctr = is_jump_E ? 3 : 2.
  - Miss, taken_E=0: no allocation, table unchanged.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents (read-before-write). The new state is visible from the next cycle.
- Mispredict (combinational from E inputs):
  - mispredict = update_valid_E & ((taken_E != pred_taken_E) | (taken_E & pred_taken_E & target_E != pred_target_E)).
  - redirect_pc = taken_E ? target_E : PCP4_E.
  - When update_valid_E=0: mispredict=0 and redirect_pc=PCP4_E.
- The PC mux gives mispredict priority over predict_taken_F. Only one instruction resolves per cycle.
- Performance counters:
  - branch_count increments on update_valid_E; mispredict_count increments on mispredict.
  - Both saturate at all-ones; no wrap.
  - stats_clr takes priority over increment in the same cycle.
- Reset mid-operation clears all valid bits immediately. Predictions become not-taken; any in-flight E-stage update is discarded.
- Tag aliasing between different PCs is permitted. A wrong target is caught by the target compare and costs one mispredict.

Test Plan:
- Reset, then lookup PC_F=0x100 → predict_taken_F=0, both counters=0.
- Taken branch: PC_E=0x100, target_E=0x80, pred_taken_E=0 → mispredict=1, redirect_pc=0x80, counters 1/1. Next cycle PC_F=0x100 → predict_taken_F=1, target 0x80 (ctr=2).
- Same branch twice more taken, then not-taken with pred_taken_E=1, PCP4_E=0x104 → ctr 2→3→3→2, mispredict=1, redirect_pc=0x104, still predicts taken afterwards.
- JALR at 0x200, first to 0x300 then to 0x400, pred_target_E=0x300 → second resolution gives mispredict=1 via target mismatch, redirect_pc=0x400, entry target becomes 0x400.
- Aliasing and same-cycle update: PC 0x040 and 0x440 share index 0 (ENTRIES=16, different tag); update 0x440 while looking up 0x040 in the same cycle → lookup uses old entry; afterwards 0x040 misses.
- Counter saturation with CNT_WIDTH=4: 20 mispredicting updates → both counters=15; stats_clr asserted with update_valid_E=1 → both 0. Async rst pulse mid-sequence → predict_taken_F=0 before the next edge.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit counters for IF lookup,
// EX-stage table update, mispredict/redirect generation and saturating statistics.
module branch_predictor #(
    parameter int WIDTH     = 32,
    parameter int ENTRIES   = 16,
    parameter int TAG_BITS  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     PC_F,
    output logic                 predict_taken_F,
    output logic [WIDTH-1:0]     predict_target_F,
    input  logic                 update_valid_E,
    input  logic                 is_jump_E,
    input  logic [WIDTH-1:0]     PC_E,
    input  logic [WIDTH-1:0]     PCP4_E,
    input  logic                 taken_E,
    input  logic [WIDTH-1:0]     target_E,
    input  logic                 pred_taken_E,
    input  logic [WIDTH-1:0]     pred_target_E,
    output logic                 mispredict,
    output logic [WIDTH-1:0]     redirect_pc,
    input  logic                 stats_clr,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int IDX_BITS = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int TAG_LO   = IDX_BITS + 2;
    localparam int TAG_HI   = IDX_BITS + TAG_BITS + 1;

    logic [ENTRIES-1:0]  valid_q;
    logic [ENTRIES-1:0]  jump_mem;
    logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
    logic [WIDTH-1:0]    target_mem [ENTRIES];
    logic [1:0]          ctr_mem    [ENTRIES];

    logic [IDX_BITS-1:0] idx_f;
    logic [IDX_BITS-1:0] idx_e;
    logic [TAG_BITS-1:0] tag_f;
    logic [TAG_BITS-1:0] tag_e;
    logic                hit_f;
    logic                hit_e;
    logic                upd_en;
    logic                alloc;
    logic                entry_we;
    logic                tgt_we;
    logic [1:0]          ctr_old;
    logic [1:0]          ctr_nxt;

    // Only the index and tag fields of the PCs take part in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PC_F, PC_E};

    assign idx_f = PC_F[IDX_BITS+1:2];
    assign tag_f = PC_F[TAG_HI:TAG_LO];
    assign idx_e = PC_E[IDX_BITS+1:2];
    assign tag_e = PC_E[TAG_HI:TAG_LO];

    // Lookup reads registered state, so a same-cycle update is seen only next cycle.
    always_comb begin
        hit_f            = valid_q[idx_f] & (tag_mem[idx_f] == tag_f);
        predict_taken_F  = hit_f & (jump_mem[idx_f] | ctr_mem[idx_f][1]);
        predict_target_F = hit_f ? target_mem[idx_f] : '0;
    end

    always_comb begin
        upd_en   = update_valid_E & ~rst;
        hit_e    = valid_q[idx_e] & (tag_mem[idx_e] == tag_e);
        ctr_old  = ctr_mem[idx_e];
        alloc    = upd_en & ~hit_e & taken_E;
        entry_we = upd_en & hit_e;
        tgt_we   = alloc | (entry_we & (taken_E | is_jump_E));
        ctr_nxt  = ctr_old;
        if (!hit_e) begin
            ctr_nxt = is_jump_E ? 2'd3 : 2'd2;
        end else if (is_jump_E) begin
            ctr_nxt = 2'd3;
        end else if (taken_E) begin
            if (ctr_old != 2'd3) ctr_nxt = ctr_old + 2'd1;
        end else begin
            if (ctr_old != 2'd0) ctr_nxt = ctr_old - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (alloc) begin
            valid_q[idx_e] <= 1'b1;
        end
    end

    // Payload storage is qualified by valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (entry_we | alloc) ctr_mem[idx_e] <= ctr_nxt;
        if (tgt_we) target_mem[idx_e] <= target_E;
        if (alloc) begin
            tag_mem[idx_e]  <= tag_e;
            jump_mem[idx_e] <= is_jump_E;
        end
    end

    always_comb begin
        mispredict = update_valid_E & ~rst &
                     ((taken_E != pred_taken_E) |
                      (taken_E & pred_taken_E & (target_E != pred_target_E)));
        redirect_pc = (update_valid_E & taken_E) ? target_E : PCP4_E;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (stats_clr) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (update_valid_E && (branch_count != '1))
                branch_count <= branch_count + CNT_WIDTH'(1);
            if (mispredict && (mispredict_count != '1))
                mispredict_count <= mispredict_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: stimulus pushes expectations into a scoreboard
// queue, a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] PC_F;
    logic        predict_taken_F;
    logic [31:0] predict_target_F;
    logic        update_valid_E;
    logic        is_jump_E;
    logic [31:0] PC_E;
    logic [31:0] PCP4_E;
    logic        taken_E;
    logic [31:0] target_E;
    logic        pred_taken_E;
    logic [31:0] pred_target_E;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        stats_clr;
    logic [3:0]  branch_count;
    logic [3:0]  mispredict_count;

    branch_predictor #(.WIDTH(32), .ENTRIES(16), .TAG_BITS(8), .CNT_WIDTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .PC_F             (PC_F),
        .predict_taken_F  (predict_taken_F),
        .predict_target_F (predict_target_F),
        .update_valid_E   (update_valid_E),
        .is_jump_E        (is_jump_E),
        .PC_E             (PC_E),
        .PCP4_E           (PCP4_E),
        .taken_E          (taken_E),
        .target_E         (target_E),
        .pred_taken_E     (pred_taken_E),
        .pred_target_E    (pred_target_E),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .stats_clr        (stats_clr),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind 0: prediction (taken, target); 1: mispredict (flag, redirect); 2: counters
    typedef struct {
        int          kind;
        int          id;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic exp_pred(input int id, input logic tk, input logic [31:0] tgt);
        sb.push_back('{0, id, {31'd0, tk}, tgt});
    endtask

    task automatic exp_mis(input int id, input logic m, input logic [31:0] redir);
        sb.push_back('{1, id, {31'd0, m}, redir});
    endtask

    task automatic exp_cnt(input int id, input logic [3:0] bc, input logic [3:0] mc);
        sb.push_back('{2, id, {28'd0, bc}, {28'd0, mc}});
    endtask

    task automatic idle();
        update_valid_E = 1'b0;
        is_jump_E      = 1'b0;
        taken_E        = 1'b0;
        pred_taken_E   = 1'b0;
        stats_clr      = 1'b0;
    endtask

    task automatic resolve(input logic jmp, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        update_valid_E = 1'b1;
        is_jump_E      = jmp;
        PC_E           = pc;
        PCP4_E         = pc + 32'd4;
        taken_E        = tk;
        target_E       = tgt;
        pred_taken_E   = ptk;
        pred_target_E  = ptgt;
        stats_clr      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                logic [31:0] act_a;
                logic [31:0] act_b;
                e = sb.pop_front();
                case (e.kind)
                    0:       begin act_a = {31'd0, predict_taken_F}; act_b = predict_target_F; end
                    1:       begin act_a = {31'd0, mispredict};      act_b = redirect_pc;      end
                    default: begin act_a = {28'd0, branch_count};    act_b = {28'd0, mispredict_count}; end
                endcase
                checks++;
                if (act_a !== e.a || act_b !== e.b) begin
                    errors++;
                    $display("FAIL %s id=%0d: got %0h/%0h, expected %0h/%0h",
                             (e.kind == 0) ? "predict" : (e.kind == 1) ? "mispredict" : "counters",
                             e.id, act_a, act_b, e.a, e.b);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin : stimulus
        rst = 1'b1;
        PC_F = 32'h100;
        PC_E = 32'h0;
        PCP4_E = 32'h104;
        target_E = 32'h0;
        pred_target_E = 32'h0;
        idle();
        #1;
        exp_pred(0, 1'b0, 32'h0);
        exp_cnt(100, 4'd0, 4'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        PC_F = 32'h100; PCP4_E = 32'h104; idle();
        exp_pred(1, 1'b0, 32'h0); exp_mis(2, 1'b0, 32'h104); exp_cnt(3, 4'd0, 4'd0); tick();

        // First taken branch at 0x100 allocates with ctr=2
        resolve(1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        exp_pred(4, 1'b0, 32'h0); exp_mis(5, 1'b1, 32'h80); tick();
        idle(); exp_pred(6, 1'b1, 32'h80); exp_cnt(7, 4'd1, 4'd1); tick();

        // ctr 2->3->3, then not-taken 3->2 still predicts taken
        resolve(1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        exp_mis(8, 1'b0, 32'h80); tick();
        resolve(1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        exp_pred(9, 1'b1, 32'h80); exp_mis(10, 1'b0, 32'h80); tick();
        resolve(1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        exp_mis(11, 1'b1, 32'h104); tick();
        idle(); exp_pred(12, 1'b1, 32'h80); exp_cnt(13, 4'd4, 4'd2); tick();

        // 2->1 predicts not-taken; then 1->0->0 stays not-taken
        resolve(1'b0, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        exp_mis(14, 1'b1, 32'h104); tick();
        idle(); exp_pred(15, 1'b0, 32'h80); exp_cnt(16, 4'd5, 4'd3); tick();
        resolve(1'b0, 32'h100, 1'b0, 32'h80, 1'b0, 32'h0);
        exp_mis(17, 1'b0, 32'h104); tick();
        resolve(1'b0, 32'h100, 1'b0, 32'h80, 1'b0, 32'h0);
        exp_mis(18, 1'b0, 32'h104); tick();
        idle(); exp_pred(19, 1'b0, 32'h80); exp_cnt(20, 4'd7, 4'd3); tick();

        // JALR at 0x200: first 0x300, then 0x400 caught by target compare
        PC_F = 32'h200;
        resolve(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
        exp_pred(21, 1'b0, 32'h0); exp_mis(22, 1'b1, 32'h300); tick();
        idle(); exp_pred(23, 1'b1, 32'h300); tick();
        resolve(1'b1, 32'h200, 1'b1, 32'h400, 1'b1, 32'h300);
        exp_mis(24, 1'b1, 32'h400); exp_pred(25, 1'b1, 32'h300); tick();
        idle(); exp_pred(26, 1'b1, 32'h400); exp_cnt(27, 4'd9, 4'd5); tick();
        PC_F = 32'h100; exp_pred(28, 1'b0, 32'h0); tick();

        // Aliasing on index 0: 0x040 then 0x440, read-before-write lookup
        PC_F = 32'h040;
        resolve(1'b0, 32'h040, 1'b1, 32'h500, 1'b0, 32'h0);
        exp_pred(29, 1'b0, 32'h0); exp_mis(30, 1'b1, 32'h500); tick();
        idle(); exp_pred(31, 1'b1, 32'h500); tick();
        resolve(1'b0, 32'h440, 1'b1, 32'h600, 1'b0, 32'h0);
        exp_pred(32, 1'b1, 32'h500); exp_mis(33, 1'b1, 32'h600); tick();
        idle(); exp_pred(34, 1'b0, 32'h0); tick();
        PC_F = 32'h440; exp_pred(35, 1'b1, 32'h600); exp_cnt(36, 4'd11, 4'd7); tick();

        // Miss with not-taken leaves the table alone
        resolve(1'b0, 32'h080, 1'b0, 32'h700, 1'b0, 32'h0);
        exp_mis(37, 1'b0, 32'h084); tick();
        idle(); exp_pred(38, 1'b1, 32'h600); exp_cnt(39, 4'd12, 4'd7); tick();

        // Counter saturation, then clear beating a same-cycle increment
        for (int i = 0; i < 20; i++) begin
            resolve(1'b0, 32'h800, 1'b0, 32'h900, 1'b1, 32'h900);
            tick();
        end
        idle(); exp_cnt(40, 4'd15, 4'd15); exp_pred(41, 1'b1, 32'h600); tick();
        resolve(1'b0, 32'h800, 1'b0, 32'h900, 1'b1, 32'h900);
        stats_clr = 1'b1;
        exp_mis(42, 1'b1, 32'h804); tick();
        resolve(1'b0, 32'h800, 1'b0, 32'h900, 1'b1, 32'h900);
        exp_cnt(43, 4'd0, 4'd0); tick();
        idle(); exp_cnt(44, 4'd1, 4'd1); tick();

        // Async reset mid-cycle with an allocating update in flight
        PC_F = 32'h440; exp_pred(45, 1'b1, 32'h600); tick();
        rst = 1'b1;
        resolve(1'b0, 32'h900, 1'b1, 32'h700, 1'b0, 32'h0);
        exp_pred(46, 1'b0, 32'h0); exp_cnt(47, 4'd0, 4'd0); tick();
        rst = 1'b0; idle();
        PC_F = 32'h900; exp_pred(48, 1'b0, 32'h0); exp_cnt(49, 4'd0, 4'd0); tick();
        PC_F = 32'h440; exp_pred(50, 1'b0, 32'h0); tick();

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
